// File: rtl/jtopll_wr_ctrl.sv
// rtl/jtopll_wr_ctrl.sv - OPLL CPU write decoder, 4-entry write FIFO and strobe replay (busy model: JTOPLL_BUSY_EN)
module jtopll_wr_ctrl #(
  parameter int FIFO_AW = 2,
  parameter int AWAIT   = 12,
  parameter int DWAIT   = 84
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] cpu_din,
  output logic       busy,
  output logic       ovf,
  output logic [7:0] dout,
  output logic [3:0] sel_ch,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_original,
  output logic       rhy_en,
  output logic [4:0] rhy_kon
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [1:0] K_ORIG = 2'd0;
  localparam logic [1:0] K_FLO  = 2'd1;
  localparam logic [1:0] K_FHI  = 2'd2;
  localparam logic [1:0] K_INST = 2'd3;

  typedef enum logic {IDLE, DRIVE} state_t;

  logic               we, we_r, wr_evt, accept;
  logic [7:0]         areg;
  logic [13:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               dec_valid;
  logic [1:0]         dec_kind;
  logic [3:0]         dec_idx;
  logic               push_req, push, full, deq, load;
  logic [13:0]        load_ent;
  logic [1:0]         ld_kind, ld_grp;
  logic [3:0]         ld_idx;
  logic [2:0]         ld_rem;
  state_t             state, state_nxt;

  assign we     = !cs_n && !wr_n;
  assign wr_evt = we && !we_r;

`ifdef JTOPLL_BUSY_EN
  localparam int CW = $clog2(((AWAIT > DWAIT) ? AWAIT : DWAIT) + 1);
  logic [CW-1:0] bcnt;

  // Busy countdown: reload on every accepted write, tick down on cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     bcnt <= '0;
    else if (accept)                bcnt <= addr ? CW'(DWAIT) : CW'(AWAIT);
    else if (cen && bcnt != '0)     bcnt <= bcnt - CW'(1);
  end

  assign busy   = (bcnt != '0);
  assign accept = wr_evt && !busy;
`else
  logic unused_cfg;
  assign unused_cfg = ^{AWAIT, DWAIT};
  assign busy       = 1'b0;
  assign accept     = wr_evt;
`endif

  // Edge detect on the combined write strobe so each low pulse is one event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) we_r <= 1'b0;
    else        we_r <= we;
  end

  // Address latch and the directly-held rhythm register (0x0E)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg    <= 8'd0;
      rhy_en  <= 1'b0;
      rhy_kon <= 5'd0;
    end else if (accept) begin
      if (!addr)              areg <= cpu_din;
      else if (areg == 8'h0E) begin
        rhy_en  <= cpu_din[5];
        rhy_kon <= cpu_din[4:0];
      end
    end
  end

  // Register decode: patch bytes, fnum low/high and instrument channel ranges
  always_comb begin
    dec_valid = 1'b0;
    dec_kind  = K_ORIG;
    dec_idx   = 4'd0;
    if (areg[7:3] == 5'd0) begin
      dec_valid = 1'b1;
      dec_idx   = {1'b0, areg[2:0]};
    end else if (areg[7:6] == 2'b00 && areg[5:4] != 2'b00 && areg[3:0] <= 4'd8) begin
      dec_valid = 1'b1;
      dec_idx   = areg[3:0];
      case (areg[5:4])
        2'b01:   dec_kind = K_FLO;
        2'b10:   dec_kind = K_FHI;
        default: dec_kind = K_INST;
      endcase
    end
  end

  // The entry being driven stays in the FIFO until its cen window ends, so a
  // dequeue in the same cycle frees the slot for a push into a full FIFO.
  assign push_req = accept && addr && dec_valid;
  assign full     = (count == CNT_FULL);
  assign push     = push_req && (!full || deq);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dec_kind, dec_idx, cpu_din};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_req && full && !deq) ovf <= 1'b1;
    end
  end

  // Pop FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pop FSM next state: load the head from IDLE, chain to the next entry at
  // the end of each cen window
  always_comb begin
    state_nxt = state;
    deq       = 1'b0;
    load      = 1'b0;
    load_ent  = mem[rd_ptr];
    case (state)
      IDLE: begin
        if (count != '0) begin
          load      = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cen) begin
          deq = 1'b1;
          if (count[FIFO_AW:1] != '0) begin
            load     = 1'b1;
            load_ent = mem[rd_ptr + PTR_ONE];
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel split into group (ch/3) and sub-slot (ch%3)
  always_comb begin
    ld_kind = load_ent[13:12];
    ld_idx  = load_ent[11:8];
    ld_grp  = (ld_idx >= 4'd6) ? 2'd2 : (ld_idx >= 4'd3) ? 2'd1 : 2'd0;
    ld_rem  = ld_idx[2:0] - (3'd3 * {1'b0, ld_grp});
  end

  // Output registers: selects and data hold their last value between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout        <= 8'd0;
      sel_ch      <= 4'd0;
      sel_group   <= 2'd0;
      sel_sub     <= 3'd0;
      up_fnumlo   <= 1'b0;
      up_fnumhi   <= 1'b0;
      up_inst     <= 1'b0;
      up_original <= 1'b0;
    end else if (load) begin
      dout        <= load_ent[7:0];
      up_original <= (ld_kind == K_ORIG);
      up_fnumlo   <= (ld_kind == K_FLO);
      up_fnumhi   <= (ld_kind == K_FHI);
      up_inst     <= (ld_kind == K_INST);
      if (ld_kind == K_ORIG) begin
        sel_sub <= ld_idx[2:0];
      end else begin
        sel_ch    <= ld_idx;
        sel_group <= ld_grp;
        sel_sub   <= ld_rem;
      end
    end else if (deq) begin
      up_fnumlo   <= 1'b0;
      up_fnumhi   <= 1'b0;
      up_inst     <= 1'b0;
      up_original <= 1'b0;
    end
  end

endmodule
